// File: rtl/ltc2308_pkg.sv
// ---------------------------------------------------------------------------
// ltc2308_pkg : shared types and config encoding for the LTC2308 sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ltc2308_pkg;

  localparam logic UNI = 1'b1;
  localparam logic SLP = 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SELECT    = 3'd1,
    WAIT_TMR  = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4,
    STORE     = 3'd5
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       is_os;
    logic [2:0] ch;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

  // Single-ended, unipolar, awake: {S/D, O/S, S1, S0, UNI, SLP}
  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    cfg_word = {1'b1, ch[0], ch[2], ch[1], UNI, SLP};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ltc2308_next_ch.sv
// ---------------------------------------------------------------------------
// ltc2308_next_ch : round-robin finder for the next enabled scan channel
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ltc2308_next_ch
  import ltc2308_pkg::*;
(
  input  logic [7:0] mask,
  input  logic [2:0] last_ch,
  output logic [2:0] next_ch,
  output logic       found,
  output logic       is_highest
);

  always_comb begin
    next_ch    = last_ch;
    found      = 1'b0;
    is_highest = 1'b0;
    // Search starts just after last_ch; offset 8 wraps back onto last_ch itself.
    for (int i = 1; i <= 8; i++) begin
      if (!found && mask[last_ch + 3'(i)]) begin
        found   = 1'b1;
        next_ch = last_ch + 3'(i);
      end
    end
    is_highest = found;
    for (int j = 0; j < 8; j++) begin
      if (mask[j] && (3'(j) > next_ch)) begin
        is_highest = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ltc2308_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ltc2308_scan_ctrl : scan / one-shot sequencer for the LTC2308 frame engine
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ltc2308_scan_ctrl
  import ltc2308_pkg::*;
#(
  parameter int FRAME_CYCLES = 100,
  parameter int DATA_W       = 12
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              scan_en,
  input  logic [7:0]        ch_mask,
  input  logic              os_req,
  input  logic [2:0]        os_ch,
  output logic              os_ack,
  output logic [DATA_W-1:0] os_data,
  input  logic [2:0]        rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              scan_wrap,
  output logic              xfer_start,
  output logic [5:0]        xfer_cfg,
  input  logic              xfer_busy,
  input  logic              xfer_done,
  input  logic [DATA_W-1:0] xfer_data
);

  localparam int              TMR_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FRAME_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [5:0]        r_cfg;
  logic [2:0]        r_last_ch;
  tag_t              r_slot_tag;
  tag_t              r_pend_tag;
  tag_t              r_res_tag;
  logic              r_slot_wrap;
  logic              r_pend_wrap;
  logic              r_res_wrap;
  logic              r_os_issued;
  logic              r_os_hold;
  logic              r_os_ack;
  logic [DATA_W-1:0] r_os_data;
  logic              r_scan_wrap;
  logic [DATA_W-1:0] r_results [8];
  logic [7:0]        r_valid;

  logic [2:0] w_next_ch;
  logic       w_found;
  logic       w_is_highest;
  logic       w_os_new;
  logic       w_scan_ok;
  logic       w_drain;
  logic       w_tmr_ok;
  logic       w_sel_os;
  logic       w_sel_scan;
  logic       w_sel_drain;
  logic       w_fire;
  logic       w_store;
  logic       w_store_scan;
  logic       w_store_os;

  ltc2308_next_ch u_next_ch (
    .mask       (ch_mask),
    .last_ch    (r_last_ch),
    .next_ch    (w_next_ch),
    .found      (w_found),
    .is_highest (w_is_highest)
  );

  // r_os_hold blocks re-issue of a served one-shot until the host drops os_req.
  assign w_os_new  = os_req && !r_os_issued && !r_os_hold;
  assign w_scan_ok = scan_en && w_found;
  assign w_drain   = r_pend_tag.valid || r_res_tag.valid;
  assign w_tmr_ok  = (r_timer == '0) && !xfer_busy;

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_os    = 1'b0;
    w_sel_scan  = 1'b0;
    w_sel_drain = 1'b0;
    w_fire      = 1'b0;
    w_store     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_os_new || w_scan_ok || w_drain) begin
          w_state_nxt = SELECT;
        end
      end
      SELECT: begin
        if (w_os_new) begin
          w_sel_os = 1'b1;
        end else if (w_scan_ok) begin
          w_sel_scan = 1'b1;
        end else if (w_drain) begin
          w_sel_drain = 1'b1;
        end
        if (w_os_new || w_scan_ok || w_drain) begin
          w_state_nxt = w_tmr_ok ? START : WAIT_TMR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_TMR: begin
        if (w_tmr_ok) begin
          w_state_nxt = START;
        end
      end
      START: begin
        w_fire      = 1'b1;
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (xfer_done) begin
          w_store     = 1'b1;
          w_state_nxt = STORE;
        end
      end
      STORE: begin
        w_state_nxt = SELECT;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_store_scan = w_store && r_res_tag.valid && !r_res_tag.is_os;
  assign w_store_os   = w_store && r_res_tag.valid &&  r_res_tag.is_os;

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (w_fire) begin
      r_timer <= TMR_LOAD;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  // Slot selection: a drain slot keeps the previous cfg and carries no tag.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_cfg       <= cfg_word(3'd0);
      r_last_ch   <= 3'd7;
      r_slot_tag  <= TAG_NONE;
      r_slot_wrap <= 1'b0;
    end else if (w_sel_os) begin
      r_cfg       <= cfg_word(os_ch);
      r_slot_tag  <= '{valid: 1'b1, is_os: 1'b1, ch: os_ch};
      r_slot_wrap <= 1'b0;
    end else if (w_sel_scan) begin
      r_cfg       <= cfg_word(w_next_ch);
      r_last_ch   <= w_next_ch;
      r_slot_tag  <= '{valid: 1'b1, is_os: 1'b0, ch: w_next_ch};
      r_slot_wrap <= w_is_highest;
    end else if (w_sel_drain) begin
      r_slot_tag  <= TAG_NONE;
      r_slot_wrap <= 1'b0;
    end
  end

  // Data seen in frame N belongs to the cfg of frame N-1.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_pend_tag  <= TAG_NONE;
      r_res_tag   <= TAG_NONE;
      r_pend_wrap <= 1'b0;
      r_res_wrap  <= 1'b0;
    end else if (w_fire) begin
      r_res_tag   <= r_pend_tag;
      r_res_wrap  <= r_pend_wrap;
      r_pend_tag  <= r_slot_tag;
      r_pend_wrap <= r_slot_wrap;
    end else if (w_store) begin
      r_res_tag.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_results[i] <= '0;
      end
      r_valid <= '0;
    end else if (w_store_scan) begin
      r_results[r_res_tag.ch] <= xfer_data;
      r_valid[r_res_tag.ch]   <= 1'b1;
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_os_ack    <= 1'b0;
      r_os_data   <= '0;
      r_scan_wrap <= 1'b0;
      r_os_issued <= 1'b0;
      r_os_hold   <= 1'b0;
    end else begin
      r_os_ack    <= w_store_os;
      r_scan_wrap <= w_store_scan && r_res_wrap;
      if (w_store_os) begin
        r_os_data <= xfer_data;
      end
      if (w_store_os) begin
        r_os_issued <= 1'b0;
        r_os_hold   <= 1'b1;
      end else begin
        if (w_sel_os) begin
          r_os_issued <= 1'b1;
        end
        if (!os_req) begin
          r_os_hold <= 1'b0;
        end
      end
    end
  end

  assign xfer_start = (r_state == START);
  assign xfer_cfg   = r_cfg;
  assign os_ack     = r_os_ack;
  assign os_data    = r_os_data;
  assign scan_wrap  = r_scan_wrap;
  assign rd_data    = r_results[rd_ch];
  assign rd_valid   = r_valid[rd_ch];

endmodule

`default_nettype wire
